main: RTL and testbench



---
 rtl/main.sv | 247 ++++++++++++++++++++++++
 tb/tb_main.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/main.sv
// Serial-loaded fixed-point linear-regression trainer.
// A bit-serial stream fills a sample table (target plus up to MAX_FEATURES
// features per row, signed Q8.8). The block then runs stochastic gradient
// descent over rows 0..N for E epochs and raises done_ when it finishes.
// The trained weights live in the 'weights' array and are read hierarchically.
module main #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int DATA_WIDTH   = 16 * (MAX_FEATURES + 1),
  parameter int DEPTH        = 1024,
  parameter int LENGTH       = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S,
  input  logic [3:0]            feat,
  input  logic [7:0]            epoch,
  input  logic [ADDR_WIDTH-1:0] data_points,
  input  logic [3:0]            learn_rate,
  output logic                  done_
);

  localparam int ROW_AW = $clog2(DEPTH);
  localparam int TERM_W = 4;
  localparam int BIT_W  = $clog2(LENGTH);
  localparam int OFF_W  = $clog2(DATA_WIDTH);

  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (LENGTH - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (LENGTH - 1));

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    MAC  = 3'd1,
    ERR  = 3'd2,
    UPD  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Sample table: one row per sample, word 0 is the target, word k is feature k.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Trained weights: index 0 is the bias, 1..F the feature weights.
  logic signed [LENGTH-1:0] weights [MAX_FEATURES+1];

  // Serial loader state.
  logic [LENGTH-2:0]     shreg;
  logic [BIT_W-1:0]      bit_cnt;
  logic [TERM_W-1:0]     word_idx;
  logic                  load_done;

  // Training state.
  logic [ADDR_WIDTH-1:0] row;
  logic [TERM_W-1:0]     term_idx;
  logic [7:0]            epoch_cnt;
  logic signed [31:0]    acc;
  logic signed [LENGTH-1:0] err;

  // Datapath helpers.
  logic [ROW_AW-1:0]        row_addr;
  logic [DATA_WIDTH-1:0]    row_data;
  logic [OFF_W-1:0]         rd_off;
  logic [OFF_W-1:0]         wr_off;
  logic [TERM_W-1:0]        wr_word;
  logic signed [LENGTH-1:0] x_cur;
  logic signed [LENGTH-1:0] y_cur;
  logic signed [LENGTH-1:0] w_cur;
  logic signed [LENGTH-1:0] w_new;
  logic signed [LENGTH-1:0] err_next;
  logic signed [31:0]       mac_prod;
  logic signed [31:0]       upd_prod;
  logic signed [31:0]       upd_step;

  logic last_term;
  logic last_row;
  logic last_epoch;
  logic bit_last;

  // Clamp a 32-bit signed value into the signed word range.
  function automatic logic signed [LENGTH-1:0] sat(input logic signed [31:0] v);
    logic signed [LENGTH-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[LENGTH-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[LENGTH-1:0];
    end else begin
      r = v[LENGTH-1:0];
    end
    return r;
  endfunction

  assign row_addr   = row[ROW_AW-1:0];
  assign last_term  = (term_idx == feat);
  assign last_row   = (row == data_points);
  assign last_epoch = ((epoch_cnt + 8'd1) == epoch);
  assign bit_last   = (bit_cnt == BIT_W'(LENGTH - 1));

  // Words arrive highest index first, so the k-th word of a row lands in slot F-k.
  assign wr_word = feat - word_idx;
  assign wr_off  = OFF_W'(wr_word * LENGTH);
  assign rd_off  = OFF_W'(term_idx * LENGTH);

  // Arithmetic for the current term: MAC product, error and weight update.
  always_comb begin
    row_data = mem[row_addr];
    x_cur    = row_data[rd_off +: LENGTH];
    y_cur    = row_data[LENGTH-1:0];
    w_cur    = weights[term_idx];
    mac_prod = 32'(w_cur) * 32'(x_cur);
    upd_prod = 32'(err) * 32'(x_cur);
    if (term_idx == '0) begin
      upd_step = 32'(err) >>> learn_rate;
    end else begin
      upd_step = (upd_prod >>> 8) >>> learn_rate;
    end
    w_new    = sat(32'(w_cur) - upd_step);
    err_next = sat(acc - 32'(y_cur));
  end

  // State register; reset always restarts at loading.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: load, then MAC/ERR/UPD per sample until the last epoch.
  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (load_done) begin
          state_next = (epoch == 8'd0) ? DONE : MAC;
        end
      end
      MAC: begin
        if (last_term) begin
          state_next = ERR;
        end
      end
      ERR: begin
        state_next = UPD;
      end
      UPD: begin
        if (last_term) begin
          state_next = (last_row && last_epoch) ? DONE : MAC;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Registered completion flag, raised on the edge that enters DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_ <= 1'b0;
    end else begin
      done_ <= (state_next == DONE);
    end
  end

  // Sample table write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (!RST && state == LOAD && !load_done && bit_last) begin
      mem[row_addr][wr_off +: LENGTH] <= {S, shreg};
    end
  end

  // Counters, accumulator, error and weights for loading and training.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      word_idx  <= '0;
      load_done <= 1'b0;
      row       <= '0;
      term_idx  <= '0;
      epoch_cnt <= '0;
      acc       <= '0;
      err       <= '0;
      for (int k = 0; k <= MAX_FEATURES; k++) begin
        weights[k] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (load_done) begin
            load_done <= 1'b0;
          end else begin
            shreg   <= {S, shreg[LENGTH-2:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_last) begin
              if (word_idx == feat) begin
                word_idx <= '0;
                if (last_row) begin
                  row       <= '0;
                  load_done <= 1'b1;
                end else begin
                  row <= row + ADDR_WIDTH'(1);
                end
              end else begin
                word_idx <= word_idx + TERM_W'(1);
              end
            end
          end
        end
        MAC: begin
          if (term_idx == '0) begin
            acc <= 32'(w_cur);
          end else begin
            acc <= acc + (mac_prod >>> 8);
          end
          term_idx <= last_term ? '0 : term_idx + TERM_W'(1);
        end
        ERR: begin
          err <= err_next;
        end
        UPD: begin
          weights[term_idx] <= w_new;
          if (last_term) begin
            term_idx <= '0;
            if (last_row) begin
              row       <= '0;
              epoch_cnt <= epoch_cnt + 8'd1;
            end else begin
              row <= row + ADDR_WIDTH'(1);
            end
          end else begin
            term_idx <= term_idx + TERM_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main.sv
// Testbench for the serial-loaded linear-regression trainer.
// Directed and random cases come from a vector table; expected weights come
// from an SGD model using plain integer arithmetic, latency from the cycle formula.
module tb_main;

  logic        CLK = 1'b0;
  logic        RST;
  logic        S;
  logic [3:0]  feat;
  logic [7:0]  epoch;
  logic [11:0] data_points;
  logic [3:0]  learn_rate;
  logic        done_;

  main dut (
    .CLK(CLK),
    .RST(RST),
    .S(S),
    .feat(feat),
    .epoch(epoch),
    .data_points(data_points),
    .learn_rate(learn_rate),
    .done_(done_)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int first_done = -1;

  logic [15:0] samp [0:63][0:15];
  longint model_w [0:15];

  typedef struct {
    string       name;
    int          f;
    int          n;
    int          e;
    int          l;
    int          kind;
    logic [15:0] x1;
    logic [15:0] y;
    int          has_exp;
    logic [15:0] exp_w0;
    logic [15:0] exp_w1;
  } vec_t;

  vec_t vecs [0:7];

  task automatic tick();
    @(posedge CLK);
    #1;
    cycle++;
    if (done_ === 1'b1 && first_done < 0) first_done = cycle;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  function automatic longint floor_div_pow2(input longint a, input int s);
    longint d;
    d = longint'(1) << s;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint to_int(input logic [15:0] v);
    return (v >= 16'h8000) ? longint'(v) - 65536 : longint'(v);
  endfunction

  // Stochastic gradient descent over the bench's own copy of the samples.
  task automatic run_model(input int f, input int n, input int e, input int l);
    longint w [0:15];
    longint acc, err, x;
    for (int k = 0; k < 16; k++) w[k] = 0;
    for (int ep = 0; ep < e; ep++) begin
      for (int r = 0; r <= n; r++) begin
        acc = w[0];
        for (int k = 1; k <= f; k++) acc += floor_div_pow2(w[k] * to_int(samp[r][k]), 8);
        err = clamp16(acc - to_int(samp[r][0]));
        w[0] = clamp16(w[0] - floor_div_pow2(err, l));
        for (int k = 1; k <= f; k++) begin
          x = to_int(samp[r][k]);
          w[k] = clamp16(w[k] - floor_div_pow2(floor_div_pow2(err * x, 8), l));
        end
      end
    end
    for (int k = 0; k < 16; k++) model_w[k] = w[k];
  endtask

  function automatic logic [15:0] weight_or();
    logic [15:0] acc;
    acc = '0;
    for (int k = 0; k < 16; k++) acc |= dut.weights[k];
    return acc;
  endfunction

  // Reset, then stream rows 0..n (words f..0, LSB first) starting on the first RST=0 edge.
  task automatic apply_stimulus(input int f, input int n, input int e, input int l);
    RST = 1'b1;
    S = 1'b0;
    feat = 4'(f);
    epoch = 8'(e);
    data_points = 12'(n);
    learn_rate = 4'(l);
    repeat (3) tick();
    cycle = 0;
    first_done = -1;
    for (int r = 0; r <= n; r++) begin
      for (int w = f; w >= 0; w--) begin
        for (int b = 0; b < 16; b++) begin
          RST = 1'b0;
          S = samp[r][w][b];
          tick();
        end
      end
    end
  endtask

  // Wait for done_, then compare latency, stickiness and every weight with the model.
  task automatic run_case(input string name, input int f, input int n, input int e, input int l);
    int exp_lat;
    logic [15:0] exp_w;
    apply_stimulus(f, n, e, l);
    exp_lat = 16 * (f + 1) * (n + 1) + e * (n + 1) * (2 * f + 3) + 1;
    while (first_done < 0 && cycle < exp_lat + 50) tick();
    check_output($sformatf("%s latency", name), first_done, exp_lat);
    repeat (3) tick();
    check_output($sformatf("%s done_hold", name), {31'b0, done_}, 32'd1);
    run_model(f, n, e, l);
    for (int k = 0; k < 16; k++) begin
      exp_w = (k <= f) ? 16'(model_w[k]) : 16'h0000;
      check_output($sformatf("%s w%0d", name, k), {16'b0, dut.weights[k]}, {16'b0, exp_w});
    end
  endtask

  initial begin
    logic [15:0] xv;
    longint diff;

    // Vector table: directed single-sample cases, E=0, then random cases.
    vecs[0] = '{"single",   1, 0, 1, 0, 0, 16'h0100, 16'h0100, 1, 16'h0100, 16'h0100};
    vecs[1] = '{"lr_shift", 1, 0, 1, 2, 0, 16'h0100, 16'h0100, 1, 16'h0040, 16'h0040};
    vecs[2] = '{"saturate", 1, 0, 1, 0, 0, 16'h7FFF, 16'h8000, 1, 16'h8001, 16'h8000};
    vecs[3] = '{"epoch0",   2, 3, 0, 1, 1, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000};
    for (int i = 4; i < 8; i++) begin
      vecs[i] = '{$sformatf("rand%0d", i), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                  int'($urandom_range(1, 3)), int'($urandom_range(0, 4)), int'($urandom_range(1, 2)),
                  16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
    end

    // Reset state after a long reset.
    RST = 1'b1;
    S = 1'b0;
    feat = 4'd1;
    epoch = 8'd1;
    data_points = 12'd0;
    learn_rate = 4'd0;
    repeat (10) tick();
    check_output("reset done_", {31'b0, done_}, 32'd0);
    check_output("reset state", 32'(dut.state), 32'd0);
    check_output("reset weights", {16'b0, weight_or()}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 64; r++) begin
        for (int w = 0; w < 16; w++) begin
          if (vecs[i].kind == 2) samp[r][w] = 16'($urandom_range(0, 1023)) - 16'd512;
          else samp[r][w] = 16'($urandom);
        end
      end
      if (vecs[i].kind == 0) begin
        samp[0][1] = vecs[i].x1;
        samp[0][0] = vecs[i].y;
      end
      run_case(vecs[i].name, vecs[i].f, vecs[i].n, vecs[i].e, vecs[i].l);
      if (vecs[i].has_exp != 0) begin
        check_output($sformatf("%s w0 table", vecs[i].name), {16'b0, dut.weights[0]}, {16'b0, vecs[i].exp_w0});
        check_output($sformatf("%s w1 table", vecs[i].name), {16'b0, dut.weights[1]}, {16'b0, vecs[i].exp_w1});
      end
    end

    // Reset asserted during the second UPD cycle of a single-sample run.
    samp[0][1] = 16'h0100;
    samp[0][0] = 16'h0100;
    apply_stimulus(1, 0, 1, 0);
    repeat (5) tick();
    check_output("mid_upd w0 before reset", {16'b0, dut.weights[0]}, 32'h0100);
    RST = 1'b1;
    tick();
    check_output("mid_upd done_", {31'b0, done_}, 32'd0);
    check_output("mid_upd state", 32'(dut.state), 32'd0);
    check_output("mid_upd weights", {16'b0, weight_or()}, 32'd0);

    // Convergence on y = 2*x1 + 1 with the second feature held at zero.
    for (int r = 0; r < 64; r++) begin
      xv = 16'($urandom_range(0, 511)) - 16'd256;
      samp[r][1] = xv;
      samp[r][2] = 16'h0000;
      samp[r][0] = 16'(2 * to_int(xv) + 256);
    end
    run_case("converge", 2, 63, 30, 2);
    diff = to_int(dut.weights[1]) - 512;
    checks++;
    if (diff > 16 || diff < -16) begin
      errors++;
      $display("[TB] FAIL converge w1 near: actual=0x%0h required=0x0200+-0x10", dut.weights[1]);
    end
    diff = to_int(dut.weights[0]) - 256;
    checks++;
    if (diff > 16 || diff < -16) begin
      errors++;
      $display("[TB] FAIL converge w0 near: actual=0x%0h required=0x0100+-0x10", dut.weights[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
